mul_8bit_seq: RTL and testbench



---
 rtl/mul_pkg.sv | 13 +
 rtl/add_8bit.sv | 21 ++
 rtl/mul_8bit_seq.sv | 125 ++++++++++++
 tb/tb_mul_8bit_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and widths for the sequential 8x8 multiplier.
package mul_pkg;

  localparam int MUL_W  = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/add_8bit.sv
// 8-bit ripple-carry adder: sum = a + b + cin, carry-out on cout.
module add_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[8];

endmodule

// File: rtl/mul_8bit_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier, one partial product per clock.
// Optional early exit once the remaining multiplier bits are all zero:
// define MUL_8BIT_SEQ_EARLY_EN to enable it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an operand pair, in_ready high
// CALC  | one shift-and-add step per clock, 8 steps (fewer with early exit)
// DONE  | product valid, held until out_ready
module mul_8bit_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product
);

  mul_state_t state, state_nxt;

  logic [7:0]  mcand;
  logic [7:0]  mplr;
  logic [7:0]  acc_hi;
  logic [7:0]  acc_lo;
  logic [2:0]  cnt;

  logic [7:0]  addend;
  logic [7:0]  add_s;
  logic        add_c;
  logic        early;
  logic        last_step;
  logic [15:0] acc_step;

  assign addend = mplr[0] ? mcand : 8'h00;

  add_8bit u_add (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (add_s),
    .cout (add_c)
  );

`ifdef MUL_8BIT_SEQ_EARLY_EN
  // No multiplier bits left: the remaining steps would only shift, so do them at once.
  logic [3:0] shamt;
  assign early    = (mplr == 8'h00);
  assign shamt    = 4'd8 - {1'b0, cnt};
  assign acc_step = early ? ({acc_hi, acc_lo} >> shamt)
                          : {add_c, add_s, acc_lo[7:1]};
`else
  assign early    = 1'b0;
  assign acc_step = {add_c, add_s, acc_lo[7:1]};
`endif

  assign last_step = (cnt == 3'd7) || early;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and input handshake.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output valid flag, registered so it is high exactly while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_nxt == DONE);
    end
  end

  // Operand capture and one shift-and-add step per CALC clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= 8'h00;
      mplr   <= 8'h00;
      acc_hi <= 8'h00;
      acc_lo <= 8'h00;
      cnt    <= 3'd0;
    end else if (state == IDLE && in_valid) begin
      mcand  <= a;
      mplr   <= b;
      acc_hi <= 8'h00;
      acc_lo <= 8'h00;
      cnt    <= 3'd0;
    end else if (state == CALC) begin
      {acc_hi, acc_lo} <= acc_step;
      mplr             <= mplr >> 1;
      cnt              <= cnt + 3'd1;
    end
  end

  assign product = {acc_hi, acc_lo};

endmodule

// File: tb/tb_mul_8bit_seq.sv
// Self-checking bench for mul_8bit_seq: behavioural timing/product model plus
// directed cases with literal expectations. Honours MUL_8BIT_SEQ_EARLY_EN.
module tb_mul_8bit_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;

  mul_8bit_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycles from accept to out_valid, from the arithmetic definition of the feature.
  function automatic int exp_lat(input logic [7:0] bv);
`ifdef MUL_8BIT_SEQ_EARLY_EN
    int hb;
    if (bv == 8'h00) return 1;
    hb = 0;
    for (int i = 0; i < 8; i++) if (bv[i]) hb = i;
    return (hb + 2 > 8) ? 8 : hb + 2;
`else
    return (bv === 8'hxx) ? 0 : 8;
`endif
  endfunction

  // Model: an accepted pair becomes a result exp_lat cycles later, held until taken.
  int          m_cyc = 0;
  int          m_done_at = 0;
  logic        m_busy = 1'b0;
  logic [15:0] m_prod = 16'h0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (!m_busy) begin
        if (in_valid) begin
          m_busy    <= 1'b1;
          m_prod    <= {8'h00, a} * {8'h00, b};
          m_done_at <= m_cyc + 1 + exp_lat(b);
        end
      end else if (m_cyc >= m_done_at && out_ready) begin
        m_busy <= 1'b0;
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_busy && (m_cyc >= m_done_at)});
    if (m_busy && m_cyc >= m_done_at)
      chk("product", {16'd0, product}, {16'd0, m_prod});
    if (!rst_n)
      chk("product_rst", {16'd0, product}, 32'd0);
  end

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk({nm, " ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string nm, output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk({nm, " valid_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] want,
                       input int want_lat, input int stall, input string nm);
    int n;
    wait_ready(nm);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(nm, n);
    chk({nm, " latency"}, n, want_lat);
    chk({nm, " prod"}, {16'd0, product}, {16'd0, want});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({nm, " held_valid"}, {31'd0, out_valid}, 32'd1);
      chk({nm, " held_prod"}, {16'd0, product}, {16'd0, want});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " ready_after"}, {31'd0, in_ready}, 32'd1);
    chk({nm, " valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int idx;
    int k;
    logic [7:0]  op_a [3];
    logic [7:0]  op_b [3];
    logic [15:0] rec_p [3];
    int          rec_t [3];

    repeat (2) @(negedge clk);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst product", {16'd0, product}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Largest operands, plus latency and in_ready low while busy (model checks the latter).
`ifdef MUL_8BIT_SEQ_EARLY_EN
    do_op(8'hFF, 8'hFF, 16'hFE01, 8, 0, "ffxff");
    do_op(8'h5A, 8'h00, 16'h0000, 1, 0, "early_b0");
    do_op(8'hAB, 8'h01, 16'h00AB, 2, 0, "early_b1");
    do_op(8'h03, 8'h80, 16'h0180, 8, 0, "early_b80");
    do_op(8'h0D, 8'h0B, 16'h008F, 5, 5, "stall");
`else
    do_op(8'hFF, 8'hFF, 16'hFE01, 8, 0, "ffxff");
    do_op(8'h0D, 8'h0B, 16'h008F, 8, 5, "stall");
`endif

    // Operands offered during CALC must be ignored.
    wait_ready("ign");
    a = 8'h03; b = 8'h05; in_valid = 1'b1;
    @(negedge clk);
    a = 8'h12; b = 8'h34;
    wait_valid("ign", n);
    chk("ign first", {16'd0, product}, 32'h000F);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid("ign2", n);
    chk("ign second", {16'd0, product}, 32'h03A8);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of a calculation.
    wait_ready("rst");
    a = 8'd200; b = 8'd100; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst product", {16'd0, product}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(8'd7, 8'd9, 16'h003F, exp_lat(8'd9), 0, "after_rst");

    // Back-to-back with in_valid and out_ready held high.
    op_a[0] = 8'h01; op_b[0] = 8'h01;
    op_a[1] = 8'h00; op_b[1] = 8'h80;
    op_a[2] = 8'h80; op_b[2] = 8'h80;
    wait_ready("b2b");
    out_ready = 1'b1;
    a = op_a[0]; b = op_b[0]; in_valid = 1'b1;
    idx = 1; k = 0;
    for (int i = 1; i < 60 && k < 3; i++) begin
      @(negedge clk);
      if (out_valid) begin
        rec_p[k] = product;
        rec_t[k] = i;
        k++;
      end
      if (in_ready) begin
        if (idx < 3) begin
          a = op_a[idx]; b = op_b[idx]; idx++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b count", k, 3);
    if (k == 3) begin
      chk("b2b p0", {16'd0, rec_p[0]}, 32'h0001);
      chk("b2b p1", {16'd0, rec_p[1]}, 32'h0000);
      chk("b2b p2", {16'd0, rec_p[2]}, 32'h4000);
`ifndef MUL_8BIT_SEQ_EARLY_EN
      chk("b2b gap01", rec_t[1] - rec_t[0], 10);
      chk("b2b gap12", rec_t[2] - rec_t[1], 10);
`endif
    end
    @(negedge clk);

    // Random traffic; the per-cycle compare against the model does the checking.
    for (int i = 0; i < 600; i++) begin
      int sel;
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 7);
      a = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h00 : 8'($urandom);
      sel = $urandom_range(0, 7);
      b = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h00 : (sel == 2) ? 8'h01 << $urandom_range(0, 7)
                                                               : 8'($urandom);
      if (i == 300) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
